fifo_rptr_empty: RTL
====================

Name: fifo_rptr_empty

Overview:
Read-domain pointer and status block of the asynchronous FIFO. It sits at the read end of the write-to-read pointer crossing. It consumes the write pointer after that pointer has been synchronized into the read clock domain. It produces the binary read address for the dual-port RAM and the Gray read pointer that is synchronized back into the write domain. It also produces the empty, almost-empty, fill-level and underflow status.

Parameters:
ADDR_SIZE, 8, RAM address width; depth = 2^ADDR_SIZE; pointers are ADDR_SIZE+1 bits (extra wrap bit)
AEMPTY_THRESH, 4, almost-empty asserts when level <= this value; legal range 0 .. 2^ADDR_SIZE-1

Ports:
clk_i  input  1  read-domain clock
rst_i  input  1  asynchronous active-low reset
rd_en_i  input  1  read request from consumer
wptr_sync_i  input  ADDR_SIZE+1  Gray write pointer, already 2-flop synchronized into clk_i domain
clr_underflow_i  input  1  clears sticky underflow flag
raddr_o  output  ADDR_SIZE  binary RAM read address
rptr_o  output  ADDR_SIZE+1  Gray read pointer (registered, glitch-free), goes to write-domain synchronizer
empty_o  output  1  FIFO empty, registered
aempty_o  output  1  almost empty, registered
rlevel_o  output  ADDR_SIZE+1  words available, registered, 0 .. 2^ADDR_SIZE
underflow_o  output  1  sticky: read attempted while empty

Behaviour:
- Reset: one clock (clk_i). Reset is asynchronous and active-low on rst_i. Assertion immediately forces:
  - internal binary pointer rbin = 0, rptr_o = 0, raddr_o = 0
  - empty_o = 1, aempty_o = 1, rlevel_o = 0, underflow_o = 0
- Deassertion is synchronous to clk_i; the source is synchronized externally.
- Reset mid-operation discards all state; there is no recovery of pointers.
- Read accept: rinc = rd_en_i & ~empty_o. A read while empty never moves the pointer.
- Next-state computation (all outputs registered, updated on the same rising edge):
  - rbin_next = rbin + rinc, modulo 2^(ADDR_SIZE+1)
  - rgray_next = (rbin_next >> 1) ^ rbin_next
  - rptr_o <= rgray_next; raddr_o <= rbin_next[ADDR_SIZE-1:0]
- Empty: empty_o <= (rgray_next == wptr_sync_i). Comparison is on the full ADDR_SIZE+1 bits, Gray domain.
  - Empty asserts on the same edge that accepts the last word.
  - Deassertion is pessimistic by the synchronizer latency, which is outside this block.
- Level:
  - wbin = Gray-to-binary of wptr_sync_i (XOR prefix from MSB).
  - rlevel_o <= (wbin - rbin_next) mod 2^(ADDR_SIZE+1).
  - Full depth (level = 2^ADDR_SIZE) is representable via the wrap bit.
  - Valid only for legal Gray inputs, i.e. one bit changing per clk_i. Illegal inputs produce an undefined level and the block does not check for them.
- Almost empty: aempty_o <= (level_next <= AEMPTY_THRESH), using the same level_next as rlevel_o.
- Underflow:
  - set term = rd_en_i & empty_o; clear term = clr_underflow_i.
  - Set wins over a simultaneous clear.
  - The flag holds until cleared or reset.
- Wrap-around:
  - raddr_o wraps every 2^ADDR_SIZE accepted reads.
  - The pointer MSB toggles at each address wrap.
  - rptr_o returns to 0 after 2^(ADDR_SIZE+1) reads.
  - Exactly one bit of rptr_o changes per accepted read; it never changes without a read.
- Simultaneous read and write-pointer advance: both take effect in the same cycle's computation. empty_o stays 0 if the words remaining after the read are > 0.
- RAM read data for raddr_o is the RAM's responsibility: registered-address, one-cycle latency. This block does not drive data.

Test Plan:
Use ADDR_SIZE=4 and AEMPTY_THRESH=4 for all scenarios.
1. Reset: run any traffic, then pull rst_i low between clock edges -> outputs go to 0 / empty_o=1 / aempty_o=1 immediately, without waiting for a clk_i edge.
2. Drain: set wptr_sync_i=0x07 (gray 5) -> after 1 edge empty_o=0, rlevel_o=5, aempty_o=0. Then hold rd_en_i=1 for 5 cycles:
   - raddr_o steps 1,2,3,4,5
   - rptr_o steps 0x01,0x03,0x02,0x06,0x07
   - aempty_o=1 from the 1st read edge (level 4)
   - empty_o=1 and rlevel_o=0 on the 5th read edge
3. Underflow:
   - rd_en_i=1 while empty -> rptr_o unchanged, underflow_o=1 next edge, stays 1
   - pulse clr_underflow_i -> 0
   - rd_en_i=1 and clr_underflow_i=1 together while empty -> underflow_o=1
4. Full depth and wrap:
   - rptr_o=0 with wptr_sync_i=0x18 (gray 16) -> rlevel_o=16, empty_o=0
   - read 16 words -> raddr_o wraps to 0, rptr_o=0x18, empty_o=1
   - continue the same pattern to 32 total reads -> rptr_o=0x00
   - confirm a single-bit change per read throughout
5. Concurrent events: 1 word available (wptr_sync_i=0x01). In one cycle assert rd_en_i and change wptr_sync_i to 0x03 -> read accepted, raddr_o=1, empty_o=0, rlevel_o=1.

Source files
------------

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and status logic for an asynchronous FIFO.
// Takes the Gray write pointer, already synchronized into clk_i, and
// produces the binary RAM read address, the registered Gray read pointer
// for the write-domain synchronizer, and the empty, almost-empty,
// fill-level and sticky underflow status.
// Every output comes straight from a flop. rptr_o therefore changes one
// bit at a time without glitches, which is what the crossing needs.

module fifo_rptr_empty #(
    parameter int ADDR_SIZE     = 8,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rd_en_i,
    input  logic [ADDR_SIZE:0]   wptr_sync_i,
    input  logic                 clr_underflow_i,
    output logic [ADDR_SIZE-1:0] raddr_o,
    output logic [ADDR_SIZE:0]   rptr_o,
    output logic                 empty_o,
    output logic                 aempty_o,
    output logic [ADDR_SIZE:0]   rlevel_o,
    output logic                 underflow_o
);

    // Pointers carry one extra wrap bit. With it, full (level = depth)
    // and empty (level = 0) can be told apart.
    localparam int PW = ADDR_SIZE + 1;
    localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic          rinc;
    logic          empty_next;
    logic          aempty_next;
    logic          underflow_next;

    // Accept a read only when there is a word to read.
    // A read while empty leaves the pointer where it is.
    always_comb begin
        rinc       = rd_en_i & ~empty_o;
        rbin_next  = rbin + {{ADDR_SIZE{1'b0}}, rinc};
        rgray_next = (rbin_next >> 1) ^ rbin_next;
    end

    // Gray-to-binary of the synchronized write pointer.
    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(wptr_sync_i >> i);
        end
    end

    // Status for the next cycle. It is based on the post-read pointer, so
    // empty and level already reflect a read accepted on this edge.
    always_comb begin
        empty_next     = (rgray_next == wptr_sync_i);
        level_next     = wbin - rbin_next;
        aempty_next    = (level_next <= AEMPTY_LVL);
        underflow_next = underflow_o;
        if (clr_underflow_i) begin
            underflow_next = 1'b0;
        end
        // A new underflow beats a clear in the same cycle, so the event is never lost.
        if (rd_en_i && empty_o) begin
            underflow_next = 1'b1;
        end
    end

    // Pointer and status registers. Asserting reset clears them at once;
    // releasing it is assumed to be already synchronized to clk_i.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rbin        <= '0;
            rptr_o      <= '0;
            empty_o     <= 1'b1;
            aempty_o    <= 1'b1;
            rlevel_o    <= '0;
            underflow_o <= 1'b0;
        end else begin
            rbin        <= rbin_next;
            rptr_o      <= rgray_next;
            empty_o     <= empty_next;
            aempty_o    <= aempty_next;
            rlevel_o    <= level_next;
            underflow_o <= underflow_next;
        end
    end

    // The RAM address is the low bits of the registered binary pointer.
    // It changes on the same edge as rptr_o.
    assign raddr_o = rbin[ADDR_SIZE-1:0];

endmodule
